// File: rtl/mp_phase_sequencer_if.sv
// Control bus between the phase sequencer and the matrix processor datapath.
// The master side is the sequencer; the slave side is the datapath/controller.
interface mp_phase_sequencer_if #(
    parameter int unsigned OP_W = 6
);
    logic            run;
    logic [OP_W-1:0] op;
    logic            mem_ready;
    logic            flag_eq;
    logic            flag_gt;
    logic            flag_ls;
    logic            ir_load;
    logic            pc_inc;
    logic            pc_load;
    logic            mem_rd;
    logic            mem_wr;
    logic            au_start;
    logic            reg_wr;
    logic            flag_wr;
    logic [2:0]      phase;
    logic            busy;
    logic            illegal;
    logic            timeout;

    modport master (
        input  run, op, mem_ready, flag_eq, flag_gt, flag_ls,
        output ir_load, pc_inc, pc_load, mem_rd, mem_wr, au_start,
               reg_wr, flag_wr, phase, busy, illegal, timeout
    );

    modport slave (
        output run, op, mem_ready, flag_eq, flag_gt, flag_ls,
        input  ir_load, pc_inc, pc_load, mem_rd, mem_wr, au_start,
               reg_wr, flag_wr, phase, busy, illegal, timeout
    );
endinterface

// File: rtl/mp_phase_sequencer.sv
// Multicycle phase sequencer: steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB and issues one-cycle datapath strobes.
// Traps (until reset) on illegal opcodes or memory timeouts.
module mp_phase_sequencer #(
    parameter int unsigned OP_W        = 6,
    parameter int unsigned MMUL_CYCLES = 4,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    mp_phase_sequencer_if.master bus
);
    localparam int unsigned ECW = $clog2(MMUL_CYCLES + 1);
    localparam int unsigned WCW = $clog2(MEM_TIMEOUT + 1);

    localparam logic [OP_W-1:0] OP_MLD    = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] OP_MSTR   = OP_W'(6'b000001);
    localparam logic [OP_W-1:0] OP_MADD   = OP_W'(6'b001000);
    localparam logic [OP_W-1:0] OP_MSUB   = OP_W'(6'b001001);
    localparam logic [OP_W-1:0] OP_MMUL   = OP_W'(6'b001100);
    localparam logic [OP_W-1:0] OP_SMUL   = OP_W'(6'b001101);
    localparam logic [OP_W-1:0] OP_MCMP   = OP_W'(6'b011000);
    localparam logic [OP_W-1:0] OP_ICMP   = OP_W'(6'b011001);
    localparam logic [OP_W-1:0] OP_JMP    = OP_W'(6'b011100);
    localparam logic [OP_W-1:0] OP_JEQ    = OP_W'(6'b011101);
    localparam logic [OP_W-1:0] OP_JGT    = OP_W'(6'b011110);
    localparam logic [OP_W-1:0] OP_JLS    = OP_W'(6'b011111);
    localparam logic [OP_W-1:0] OP_ZERO   = OP_W'(6'b100100);
    localparam logic [OP_W-1:0] OP_INT_LO = OP_W'(6'b010000);
    localparam logic [OP_W-1:0] OP_INT_HI = OP_W'(6'b010111);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        TRAP   = 3'd6
    } state_t;

    state_t          state;
    logic [ECW-1:0]  exec_cnt;
    logic [WCW-1:0]  wait_cnt;
    logic [OP_W-1:0] op_q;
    logic            illegal_q;
    logic            timeout_q;

    logic is_mld, is_mstr, is_mul, is_cmp, is_jump, taken, exec_last, wait_expired;

    function automatic logic is_legal(input logic [OP_W-1:0] o);
        case (o)
            OP_MLD, OP_MSTR, OP_MADD, OP_MSUB, OP_MMUL, OP_SMUL,
            OP_MCMP, OP_ICMP, OP_JMP, OP_JEQ, OP_JGT, OP_JLS, OP_ZERO:
                return 1'b1;
            default:
                return (o >= OP_INT_LO) && (o <= OP_INT_HI);
        endcase
    endfunction

    // Opcode class decode from the latched opcode, plus counter end conditions.
    always_comb begin
        is_mld       = (op_q == OP_MLD);
        is_mstr      = (op_q == OP_MSTR);
        is_mul       = (op_q == OP_MMUL) || (op_q == OP_SMUL);
        is_cmp       = (op_q == OP_MCMP) || (op_q == OP_ICMP);
        is_jump      = (op_q == OP_JMP) || (op_q == OP_JEQ) ||
                       (op_q == OP_JGT) || (op_q == OP_JLS);
        taken        = (op_q == OP_JMP) ||
                       ((op_q == OP_JEQ) && bus.flag_eq) ||
                       ((op_q == OP_JGT) && bus.flag_gt) ||
                       ((op_q == OP_JLS) && bus.flag_ls);
        exec_last    = is_mul ? (exec_cnt == ECW'(MMUL_CYCLES - 1)) : 1'b1;
        wait_expired = (wait_cnt == WCW'(MEM_TIMEOUT - 1));
    end

    // Phase state machine, counters, opcode latch and sticky trap causes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            exec_cnt  <= '0;
            wait_cnt  <= '0;
            op_q      <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.run) begin
                        state    <= FETCH;
                        wait_cnt <= '0;
                    end
                end
                FETCH: begin
                    if (bus.mem_ready) begin
                        state <= DECODE;
                    end else if (wait_expired) begin
                        state     <= TRAP;
                        timeout_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WCW'(1);
                    end
                end
                DECODE: begin
                    op_q     <= bus.op;
                    exec_cnt <= '0;
                    if (is_legal(bus.op)) begin
                        state <= EXEC;
                    end else begin
                        state     <= TRAP;
                        illegal_q <= 1'b1;
                    end
                end
                EXEC: begin
                    if (!exec_last) begin
                        exec_cnt <= exec_cnt + ECW'(1);
                    end else if (is_mld || is_mstr) begin
                        state    <= MEM;
                        wait_cnt <= '0;
                    end else if (is_cmp || is_jump) begin
                        state    <= bus.run ? FETCH : IDLE;
                        wait_cnt <= '0;
                    end else begin
                        state <= WB;
                    end
                end
                MEM: begin
                    if (bus.mem_ready) begin
                        if (is_mld) begin
                            state <= WB;
                        end else begin
                            state    <= bus.run ? FETCH : IDLE;
                            wait_cnt <= '0;
                        end
                    end else if (wait_expired) begin
                        state     <= TRAP;
                        timeout_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WCW'(1);
                    end
                end
                WB: begin
                    state    <= bus.run ? FETCH : IDLE;
                    wait_cnt <= '0;
                end
                TRAP: begin
                    state <= TRAP;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Strobes and status derived from the current phase; mem_ready only
    // matters in FETCH and MEM, and trap causes are visible from TRAP on.
    always_comb begin
        bus.ir_load  = 1'b0;
        bus.pc_inc   = 1'b0;
        bus.pc_load  = 1'b0;
        bus.mem_rd   = 1'b0;
        bus.mem_wr   = 1'b0;
        bus.au_start = 1'b0;
        bus.reg_wr   = 1'b0;
        bus.flag_wr  = 1'b0;
        bus.phase    = state;
        bus.busy     = (state == FETCH) || (state == DECODE) || (state == EXEC) ||
                       (state == MEM)   || (state == WB);
        bus.illegal  = illegal_q;
        bus.timeout  = timeout_q;
        case (state)
            FETCH: begin
                bus.mem_rd  = 1'b1;
                bus.ir_load = bus.mem_ready;
            end
            EXEC: begin
                bus.au_start = (exec_cnt == '0);
                if (exec_last) begin
                    if (is_cmp) begin
                        bus.flag_wr = 1'b1;
                        bus.pc_inc  = 1'b1;
                    end else if (is_jump) begin
                        bus.pc_load = taken;
                        bus.pc_inc  = !taken;
                    end
                end
            end
            MEM: begin
                bus.mem_rd = is_mld;
                bus.mem_wr = is_mstr;
                bus.pc_inc = is_mstr && bus.mem_ready;
            end
            WB: begin
                bus.reg_wr = 1'b1;
                bus.pc_inc = 1'b1;
            end
            default: begin
            end
        endcase
    end
endmodule
